regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file for the pipelined core's decode stage, succeeding the fixed 32×32 two-read-port register file. It adds configurable data width and register count, a hardwired zero register, write-to-read bypass, and a per-register busy scoreboard. Decode uses the scoreboard to detect RAW hazards against in-flight producers; writeback retires them.

## Interface
- XLEN, 32, data width in bits.
- AREG, 5, address width; register count NREGS = 2**AREG.
- BYPASS, 1, 1 = same-cycle writeback data/busy forwarded to read ports; 0 = reads return stored state only.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy; 0 = register 0 is ordinary.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs1_addr  in  AREG  read port 1 address.
- rs2_addr  in  AREG  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- rs1_busy  out  1  port 1 register has an outstanding producer.
- rs2_busy  out  1  port 2 register has an outstanding producer.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AREG  writeback destination.
- wr_data  in  XLEN  writeback data.
- alloc_en  in  1  request to mark alloc_addr busy (instruction issue).
- alloc_addr  in  AREG  destination being allocated.
- alloc_ready  out  1  alloc_addr may be allocated this cycle.
- flush  in  1  clear all busy bits (pipeline flush).

## Operation
- State: NREGS × XLEN data array and NREGS busy bits; no other state.
- Reset (reset=0, asynchronous): all data = 0, all busy = 0. During reset, rs*_data = 0, rs*_busy = 0, alloc_ready = 1.
- Write: on an edge with wr_en=1, reg[wr_addr] ← wr_data and busy[wr_addr] ← 0, unless wr_addr=0 and ZERO_REG=1 (no effect).
- Allocate handshake: alloc_ready = !busy[alloc_addr], or 1 when alloc_addr=0 and ZERO_REG=1. An allocation occurs on an edge with alloc_en=1 and alloc_ready=1, setting busy[alloc_addr] ← 1 (never for register 0 when ZERO_REG=1). alloc_en with alloc_ready=0 is ignored; the requester holds and retries.
- alloc_ready ignores same-cycle writeback. Allocating a register while its producer retires in that cycle therefore waits one cycle. This is deliberate and keeps alloc_ready independent of wr_*.
- Same register, same edge, wr_en and accepted alloc_en: data written, busy ends 1 (new producer wins).
- flush=1: all busy bits ← 0 on the edge, overriding any same-edge allocation. A same-edge write still updates data.
- Read, BYPASS=1: if wr_en=1, wr_addr=rsN_addr, and the address is not a zero register, then rsN_data = wr_data and rsN_busy = 0. Otherwise rsN_data = reg[rsN_addr] and rsN_busy = busy[rsN_addr].
- Read, BYPASS=0: always stored values.
- ZERO_REG=1 with rsN_addr=0: rsN_data = 0 and rsN_busy = 0 regardless of other inputs.
- Both read ports are independent; both may address the same register.

## Timing
- Write latency: 1 edge to storage; 0 cycles to read ports when BYPASS=1.
- Allocate latency: busy is visible on read ports and alloc_ready the cycle after the accepting edge.
- Reads, busy, and alloc_ready are purely combinational from current state and inputs; no registered outputs.
- Reset deassertion takes effect on the next rising edge; reset assertion mid-operation clears everything immediately, discarding pending writes and allocations.

## Test plan
- Reset/readout: assert reset for 2 cycles, then read all NREGS addresses on both ports -> every data = 0, busy = 0, alloc_ready = 1.
- Write/bypass (BYPASS=1): wr_en, wr_addr=5, wr_data=0xDEADBEEF, rs1_addr=rs2_addr=5 in the same cycle -> both ports return 0xDEADBEEF. With BYPASS=0 -> old value that cycle, 0xDEADBEEF the next.
- Zero register: write 0x12345678 to address 0 and allocate 0 -> reads of address 0 return 0, busy = 0, alloc_ready = 1. With ZERO_REG=0 -> the read returns 0x12345678 and the busy behaviour is normal.
- Scoreboard: alloc 7 -> next cycle rs1_busy = 1 and alloc_ready(7) = 0. A retried alloc 7 has no effect. Write 7 = 0xA5 -> busy clears; BYPASS=1 shows rs1_busy = 0 and data 0xA5 in the write cycle.
- Simultaneous events: busy[3] = 1, then a write to 3 coinciding with alloc 3 -> alloc refused (alloc_ready = 0) and busy = 0 after. Alloc 4 with a flush on the same edge -> busy[4] = 0. A write and an accepted alloc to the same free register -> data updated, busy = 1.
- Async reset mid-operation: busy[9] = 1 and reg[9] = 0x55, pulse reset between edges -> immediately rs1_data(9) = 0 and busy = 0.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised GPR file with an optional hardwired zero register,
// write-to-read bypass and a per-register busy scoreboard for RAW detection.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int AREG     = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AREG-1:0] rs1_addr,
    input  logic [AREG-1:0] rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AREG-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            alloc_en,
    input  logic [AREG-1:0] alloc_addr,
    output logic            alloc_ready,
    input  logic            flush
);

    localparam int NREGS = 1 << AREG;

    logic [XLEN-1:0]  data_q [NREGS];
    logic [XLEN-1:0]  data_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic             alloc_ok;
    logic             alloc_fire;
    logic             wr_fire;

    // True when the address names the hardwired zero register.
    function automatic logic is_zero(input logic [AREG-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Read one port: zero register, then bypass, then stored state.
    // Returns {busy, data}.
    function automatic logic [XLEN:0] read_port(input logic [AREG-1:0] addr);
        logic [XLEN:0] r;
        if (is_zero(addr)) begin
            r = '0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
            r = {1'b0, wr_data};
        end else begin
            r = {busy_q[addr], data_q[addr]};
        end
        return r;
    endfunction

    // Allocation handshake and write qualification; independent of wr_* so
    // a retiring producer makes a same-cycle allocation wait one cycle.
    always_comb begin
        alloc_ok   = is_zero(alloc_addr) ? 1'b1 : !busy_q[alloc_addr];
        alloc_fire = alloc_en && alloc_ok && !is_zero(alloc_addr);
        wr_fire    = wr_en && !is_zero(wr_addr);
    end

    // Next-state: write retires the producer, an accepted allocation then
    // wins on the same register, and flush overrides every busy bit.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first;
        // otherwise a path that skips the assignment infers a latch.
        data_d = data_q;
        busy_d = busy_q;
        if (wr_fire) begin
            data_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (alloc_fire) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // State registers with asynchronous clear of data and scoreboard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the data array is reset on purpose: reads after reset must
            // return zero, so this storage cannot map to a reset-less RAM.
            for (int i = 0; i < NREGS; i++) begin
                data_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value regardless of statement order.
            for (int i = 0; i < NREGS; i++) begin
                data_q[i] <= data_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Read ports and alloc_ready; forced to their idle values while in reset
    // so bypassed write data cannot leak out during reset.
    always_comb begin
        logic [XLEN:0] p1;
        logic [XLEN:0] p2;
        p1 = read_port(rs1_addr);
        p2 = read_port(rs2_addr);
        if (!reset) begin
            p1 = '0;
            p2 = '0;
        end
        rs1_busy    = p1[XLEN];
        rs1_data    = p1[XLEN-1:0];
        rs2_busy    = p2[XLEN];
        rs2_data    = p2[XLEN-1:0];
        alloc_ready = !reset || alloc_ok;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb. Three instances share the stimulus:
// a = BYPASS 1 / ZERO_REG 1, b = BYPASS 0 / ZERO_REG 1, c = BYPASS 1 / ZERO_REG 0.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, alloc_addr;
    logic [31:0] wr_data;
    logic        wr_en, alloc_en, flush;

    logic [31:0] rs1_data_a, rs2_data_a, rs1_data_b, rs2_data_b, rs1_data_c, rs2_data_c;
    logic        rs1_busy_a, rs2_busy_a, rs1_busy_b, rs2_busy_b, rs1_busy_c, rs2_busy_c;
    logic        alloc_ready_a, alloc_ready_b, alloc_ready_c;

    int n_checks = 0;
    int n_errors = 0;

    regfile_sb #(.XLEN(32), .AREG(5), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_a), .rs2_data(rs2_data_a),
        .rs1_busy(rs1_busy_a), .rs2_busy(rs2_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready_a),
        .flush(flush)
    );

    regfile_sb #(.XLEN(32), .AREG(5), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_b), .rs2_data(rs2_data_b),
        .rs1_busy(rs1_busy_b), .rs2_busy(rs2_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready_b),
        .flush(flush)
    );

    regfile_sb #(.XLEN(32), .AREG(5), .BYPASS(1), .ZERO_REG(0)) dut_c (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data_c), .rs2_data(rs2_data_c),
        .rs1_busy(rs1_busy_c), .rs2_busy(rs2_busy_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready_c),
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        alloc_en = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        rs1_addr = '0; rs2_addr = '0; wr_addr = '0; alloc_addr = '0;
        wr_data = '0;
        idle();

        // Reset held for two edges; a write attempt must not leak through.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF; rs1_addr = 5'd5;
        tick();
        tick();
        check("in_reset_rs1_data", rs1_data_a, 32'h0);
        check("in_reset_alloc_ready", {31'b0, alloc_ready_a}, 32'h1);
        idle();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); alloc_addr = 5'(i);
            #1;
            check($sformatf("rst_rs1_data[%0d]", i), rs1_data_a, 32'h0);
            check($sformatf("rst_rs2_data[%0d]", 31 - i), rs2_data_a, 32'h0);
            check($sformatf("rst_busy[%0d]", i), {30'b0, rs1_busy_a, rs2_busy_a}, 32'h0);
            check($sformatf("rst_alloc_ready[%0d]", i), {31'b0, alloc_ready_a}, 32'h1);
        end

        // Write with same-cycle read of the same register.
        tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        check("byp_rs1", rs1_data_a, 32'hDEAD_BEEF);
        check("byp_rs2", rs2_data_a, 32'hDEAD_BEEF);
        check("nobyp_old", rs1_data_b, 32'h0);
        tick();
        idle();
        #1;
        check("nobyp_next", rs1_data_b, 32'hDEAD_BEEF);
        check("byp_stored", rs2_data_a, 32'hDEAD_BEEF);

        // Zero register: write and allocate address 0.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
        alloc_en = 1'b1; alloc_addr = 5'd0; rs1_addr = 5'd0;
        #1;
        check("zero_rd_same", rs1_data_a, 32'h0);
        check("zero_ready_same", {31'b0, alloc_ready_a}, 32'h1);
        check("nz_byp_same", rs1_data_c, 32'h1234_5678);
        check("nz_ready_same", {31'b0, alloc_ready_c}, 32'h1);
        tick();
        idle();
        #1;
        check("zero_rd_next", rs1_data_a, 32'h0);
        check("zero_busy_next", {31'b0, rs1_busy_a}, 32'h0);
        check("zero_ready_next", {31'b0, alloc_ready_a}, 32'h1);
        check("zero_rd_nobyp", rs1_data_b, 32'h0);
        check("nz_rd_next", rs1_data_c, 32'h1234_5678);
        check("nz_busy_next", {31'b0, rs1_busy_c}, 32'h1);
        check("nz_ready_next", {31'b0, alloc_ready_c}, 32'h0);

        // Scoreboard: allocate 7, retry while busy, then retire.
        alloc_en = 1'b1; alloc_addr = 5'd7; rs1_addr = 5'd7;
        #1;
        check("sb_ready_free", {31'b0, alloc_ready_a}, 32'h1);
        tick();
        check("sb_busy_after", {31'b0, rs1_busy_a}, 32'h1);
        check("sb_ready_busy", {31'b0, alloc_ready_a}, 32'h0);
        tick();
        check("sb_retry_busy", {31'b0, rs1_busy_a}, 32'h1);
        alloc_en = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_00A5;
        #1;
        check("sb_byp_busy", {31'b0, rs1_busy_a}, 32'h0);
        check("sb_byp_data", rs1_data_a, 32'h0000_00A5);
        check("sb_ready_ignores_wr", {31'b0, alloc_ready_a}, 32'h0);
        check("sb_nobyp_busy", {31'b0, rs1_busy_b}, 32'h1);
        check("sb_nobyp_data", rs1_data_b, 32'h0);
        tick();
        idle();
        #1;
        check("sb_ret_busy", {31'b0, rs1_busy_b}, 32'h0);
        check("sb_ret_data", rs1_data_b, 32'h0000_00A5);
        check("sb_ret_ready", {31'b0, alloc_ready_a}, 32'h1);

        // Write to busy 3 coinciding with alloc 3: alloc refused.
        alloc_en = 1'b1; alloc_addr = 5'd3;
        tick();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033; rs1_addr = 5'd3;
        #1;
        check("sim3_ready", {31'b0, alloc_ready_a}, 32'h0);
        tick();
        idle();
        #1;
        check("sim3_busy", {31'b0, rs1_busy_a}, 32'h0);
        check("sim3_data", rs1_data_a, 32'h0000_0033);
        check("sim3_ready_after", {31'b0, alloc_ready_a}, 32'h1);

        // Flush clears busy 6 and overrides a same-edge alloc 4; a same-edge
        // write to 10 still lands.
        alloc_en = 1'b1; alloc_addr = 5'd6;
        tick();
        alloc_addr = 5'd4; flush = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0000_1010;
        rs1_addr = 5'd4; rs2_addr = 5'd6;
        #1;
        check("fl_pre_busy6", {31'b0, rs2_busy_a}, 32'h1);
        tick();
        idle();
        #1;
        check("fl_busy4", {31'b0, rs1_busy_a}, 32'h0);
        check("fl_busy6", {31'b0, rs2_busy_a}, 32'h0);
        rs1_addr = 5'd10;
        #1;
        check("fl_wr_data", rs1_data_b, 32'h0000_1010);

        // Write and accepted alloc to the same free register.
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h0000_0088;
        alloc_en = 1'b1; alloc_addr = 5'd8; rs1_addr = 5'd8;
        #1;
        check("wa8_ready", {31'b0, alloc_ready_a}, 32'h1);
        tick();
        idle();
        #1;
        check("wa8_data", rs1_data_a, 32'h0000_0088);
        check("wa8_busy", {31'b0, rs1_busy_a}, 32'h1);
        check("wa8_ready_after", {31'b0, alloc_ready_a}, 32'h0);

        // Async reset mid-operation.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0055;
        tick();
        idle();
        alloc_en = 1'b1; alloc_addr = 5'd9;
        tick();
        idle();
        rs1_addr = 5'd9; rs2_addr = 5'd5;
        #1;
        check("ar_pre_data", rs1_data_a, 32'h0000_0055);
        check("ar_pre_busy", {31'b0, rs1_busy_a}, 32'h1);
        reset = 1'b0;
        #1;
        check("ar_data9", rs1_data_a, 32'h0);
        check("ar_busy9", {31'b0, rs1_busy_a}, 32'h0);
        check("ar_data5", rs2_data_a, 32'h0);
        reset = 1'b1;
        tick();
        check("ar_post_data9", rs1_data_b, 32'h0);
        check("ar_post_busy9", {31'b0, rs1_busy_b}, 32'h0);
        check("ar_post_data5", rs2_data_b, 32'h0);
        check("ar_post_ready", {31'b0, alloc_ready_a}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
